alu_flag_unit: RTL and testbench
================================

# alu_flag_unit

Execute-stage arithmetic/logic unit that computes the 16 ARM data-processing operations plus an iterative shift-add multiply. It produces a registered result and the Z, N, C, V flags for the status register. Its flag outputs and `flag_load` strobe connect directly to the status register's `z_in/n_in/c_in/v_in` and `load` inputs. The current flags are fed back through `flags_in` for ADC/SBC/RSC and for flag preservation.

## Interface
- `WIDTH`, 32, operand/result width (≥ 4).
- `clk` input 1 — rising-edge clock.
- `reset` input 1 — synchronous, active-high.
- `start` input 1 — request; accepted only while `busy`=0.
- `op` input 4 — ARM opcode: AND 0, EOR 1, SUB 2, RSB 3, ADD 4, ADC 5, SBC 6, RSC 7, TST 8, TEQ 9, CMP A, CMN B, ORR C, MOV D, BIC E, MVN F.
- `mul` input 1 — 1 selects multiply; `op` is ignored.
- `s_bit` input 1 — set-flags request.
- `a`, `b` input WIDTH — operands (Rn, shifter operand).
- `flags_in` input 4 — current status register, order [V, C, N, Z].
- `result` output WIDTH — registered result.
- `z_out`, `n_out`, `c_out`, `v_out` output 1 each — registered flags.
- `flag_load` output 1 — one-cycle strobe to the status register `load` input.
- `wr_en` output 1 — one-cycle strobe: `result` is to be written to Rd.
- `done` output 1 — one-cycle completion pulse.
- `busy` output 1 — multiply in progress.

## Operation
- **States:** IDLE, MUL.
- **IDLE + start + !mul:** compute in one step. Register `result` and the four flags, pulse `done`, stay IDLE.
- **IDLE + start + mul:** latch `a`, `b`, `s_bit` and `flags_in`. Clear the accumulator, set `cnt`=WIDTH, go to MUL.
- **MUL, each cycle:**
  - if multiplier LSB=1, accumulator += multiplicand (mod 2^WIDTH);
  - shift the multiplicand left and the multiplier right;
  - `cnt`--.
  - When `cnt` reaches 0: register `result`, pulse `done`, return to IDLE.
- **Arithmetic ops:**
  - N = result MSB.
  - Z = (result==0).
  - C = carry out of bit WIDTH-1. For SUB/RSB/SBC/CMP/RSC, C = NOT borrow (ARM).
  - V = signed overflow.
  - SBC = a−b−!C_in; RSC = b−a−!C_in; ADC = a+b+C_in.
- **Logical ops (AND, EOR, TST, TEQ, ORR, MOV, BIC, MVN):** N and Z from the result; C = `flags_in`[2]; V = `flags_in`[3].
- **Multiply:** N and Z from the low WIDTH bits; C and V are copied from the latched `flags_in`.
- **Test ops (TST/TEQ/CMP/CMN):** `wr_en`=0 and `flag_load`=1 regardless of `s_bit`.
- **All other ops:** `wr_en`=1; `flag_load`=`s_bit`. Both strobes coincide with `done`.
- **Hold behaviour:** `result` and the flag outputs hold until the next completion. A test op still updates the internal `result` register; `wr_en`=0 marks it as not to be written.
- **Start while busy:** ignored, not queued.
- **Reset:**
  - Values: state IDLE; `result`=0; all flags 0; `done`, `flag_load`, `wr_en`, `busy` = 0.
  - Reset mid-multiply aborts the multiply with no `done`.
  - Reset dominates a simultaneous `start`.

## Timing
- **Single-cycle op:** with `start` sampled at edge k, outputs and strobes are valid after edge k+1, for one cycle.
- **Multiply:**
  - `busy`=1 after edge k through edge k+WIDTH.
  - `done`, `wr_en` and `flag_load` are valid after edge k+WIDTH (32 cycles at default WIDTH).
- **Back-to-back:** a new `start` is accepted in the same cycle `done` is high, giving one op per cycle for non-multiply ops.
- **Status register update:** the status register captures the flags one edge after `flag_load`, so the updated flags reach `flags_in` two edges after `done`. Dependent ADC/SBC/RSC ops must be issued accordingly; the unit does not forward.

## Structure
- **Shared package `alu_pkg`:**
  - opcode localparams (OP_AND … OP_MVN);
  - state encoding (ST_IDLE, ST_MUL);
  - flag bit indices (FLAG_Z=0, FLAG_N=1, FLAG_C=2, FLAG_V=3), matching the status register order.
- **Sub-module `shift_add_multiplier`:** owns the multiplicand/multiplier/accumulator registers and `cnt`, with `go`, `clk`, `reset`, `last` and `product` ports. The top level holds the opcode datapath and the output registers.

## Test plan
- ADD a=0x7FFFFFFF, b=1, s_bit=1 -> after 1 cycle: `result`=0x80000000, {V,C,N,Z}=1010, `flag_load`=1, `wr_en`=1, `done`=1 for exactly one cycle.
- CMP a=5, b=5, s_bit=0 -> `wr_en`=0, `flag_load`=1, {V,C,N,Z}=0101.
- ADC a=0xFFFFFFFF, b=0, flags_in=0100 (C=1), s_bit=1 -> `result`=0, {V,C,N,Z}=0101.
- MUL a=0x0000FFFF, b=0x00010001, s_bit=1, flags_in=1100:
  - `result`=0xFFFFFFFF, {V,C,N,Z}=1110;
  - `done` exactly 32 cycles after `start`;
  - `start` pulses during `busy` produce no extra `done`.
- MUL started, `reset` asserted on cycle 10 -> next cycle all outputs 0, no `done` ever appears. An ADD issued next is accepted normally.
- AND a=0xF0F0F0F0, b=0x0FF00FF0, s_bit=0, flags_in=1111 -> `result`=0x00F000F0, `flag_load`=0, `wr_en`=1, flag outputs {V,C,N,Z}=1100.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared definitions for the execute-stage ALU and its flag
//               unit. Contains opcodes, FSM states, status-flag bit indices
//               and opcode classification helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // ARM data-processing opcodes
    localparam logic [3:0] OP_AND = 4'h0;
    localparam logic [3:0] OP_EOR = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_RSB = 4'h3;
    localparam logic [3:0] OP_ADD = 4'h4;
    localparam logic [3:0] OP_ADC = 4'h5;
    localparam logic [3:0] OP_SBC = 4'h6;
    localparam logic [3:0] OP_RSC = 4'h7;
    localparam logic [3:0] OP_TST = 4'h8;
    localparam logic [3:0] OP_TEQ = 4'h9;
    localparam logic [3:0] OP_CMP = 4'hA;
    localparam logic [3:0] OP_CMN = 4'hB;
    localparam logic [3:0] OP_ORR = 4'hC;
    localparam logic [3:0] OP_MOV = 4'hD;
    localparam logic [3:0] OP_BIC = 4'hE;
    localparam logic [3:0] OP_MVN = 4'hF;

    // Control FSM states, explicit 1-bit encoding
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

    // Bit positions inside the 4-bit flag vector {V, C, N, Z}
    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;

    // TST, TEQ, CMP and CMN only update flags and never write Rd
    function automatic logic is_test_op(input logic [3:0] op);
        return (op[3:2] == 2'b10);
    endfunction

endpackage
`default_nettype wire

// File: rtl/shift_add_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : shift_add_multiplier
// Description : Iterative shift-add multiplier producing the low WIDTH bits
//               of a*b. One partial-product step per cycle, WIDTH steps per
//               product. 'last' flags the final step; 'product' already
//               includes that step so the parent can capture it directly.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_add_multiplier #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             last,
    output logic [WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_step;

    // Conditional add of the multiplicand for the current multiplier bit
    always_comb begin
        acc_step = acc_q;
        if (mplier_q[0]) begin
            acc_step = acc_q + mcand_q;
        end
    end

    // Load on go, otherwise advance one step while steps remain
    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        if (go) begin
            mcand_d  = a;
            mplier_d = b;
            acc_d    = '0;
            cnt_d    = CW'(WIDTH);
        end else if (cnt_q != '0) begin
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            acc_d    = acc_step;
            cnt_d    = cnt_q - CW'(1);
        end
    end

    // Datapath registers; clearing cnt on reset kills any multiply in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end

    assign last    = (cnt_q == CW'(1)) && !go;
    assign product = acc_step;

endmodule
`default_nettype wire

// File: rtl/alu_flag_unit.sv
`default_nettype none
// ============================================================================
// Module      : alu_flag_unit
// Description : Execute-stage ALU. Single-cycle ARM data-processing ops and
//               an iterative multiply, with registered result, Z/N/C/V flags
//               and done / wr_en / flag_load strobes for the register file
//               and status register.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_flag_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic             mul,
    input  logic             s_bit,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       flags_in,
    output logic [WIDTH-1:0] result,
    output logic             z_out,
    output logic             n_out,
    output logic             c_out,
    output logic             v_out,
    output logic             flag_load,
    output logic             wr_en,
    output logic             done,
    output logic             busy
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [3:0]       flags_q, flags_d;
    logic             done_q, done_d;
    logic             wr_en_q, wr_en_d;
    logic             flag_load_q, flag_load_d;
    logic             busy_q, busy_d;
    logic             s_lat_q, s_lat_d;
    logic             c_lat_q, c_lat_d;
    logic             v_lat_q, v_lat_d;

    logic             mul_go;
    logic             mul_last;
    logic [WIDTH-1:0] mul_product;

    logic [WIDTH-1:0] alu_res;
    logic [3:0]       alu_flags;
    logic             is_arith;
    logic [WIDTH-1:0] add_x, add_y;
    logic             add_cin;
    logic [WIDTH:0]   add_sum;

    // Only C and V of the incoming flags are ever consumed
    logic             unused_flags;
    assign unused_flags = ^{flags_in[FLAG_N], flags_in[FLAG_Z]};

    shift_add_multiplier #(
        .WIDTH (WIDTH)
    ) u_mult (
        .clk     (clk),
        .reset   (reset),
        .go      (mul_go),
        .a       (a),
        .b       (b),
        .last    (mul_last),
        .product (mul_product)
    );

    // Opcode datapath: subtractions are done as x + ~y + cin so the adder
    // carry-out is directly the ARM "not borrow" C flag
    always_comb begin
        alu_res  = '0;
        is_arith = 1'b0;
        add_x    = a;
        add_y    = b;
        add_cin  = 1'b0;
        case (op)
            OP_AND, OP_TST: alu_res = a & b;
            OP_EOR, OP_TEQ: alu_res = a ^ b;
            OP_ORR:         alu_res = a | b;
            OP_MOV:         alu_res = b;
            OP_BIC:         alu_res = a & ~b;
            OP_MVN:         alu_res = ~b;
            OP_SUB, OP_CMP: begin
                is_arith = 1'b1;
                add_y    = ~b;
                add_cin  = 1'b1;
            end
            OP_RSB: begin
                is_arith = 1'b1;
                add_x    = b;
                add_y    = ~a;
                add_cin  = 1'b1;
            end
            OP_ADD, OP_CMN: begin
                is_arith = 1'b1;
            end
            OP_ADC: begin
                is_arith = 1'b1;
                add_cin  = flags_in[FLAG_C];
            end
            OP_SBC: begin
                is_arith = 1'b1;
                add_y    = ~b;
                add_cin  = flags_in[FLAG_C];
            end
            OP_RSC: begin
                is_arith = 1'b1;
                add_x    = b;
                add_y    = ~a;
                add_cin  = flags_in[FLAG_C];
            end
            default: alu_res = '0;
        endcase

        add_sum = {1'b0, add_x} + {1'b0, add_y} + {{WIDTH{1'b0}}, add_cin};
        if (is_arith) begin
            alu_res = add_sum[WIDTH-1:0];
        end

        alu_flags         = '0;
        alu_flags[FLAG_Z] = (alu_res == '0);
        alu_flags[FLAG_N] = alu_res[WIDTH-1];
        if (is_arith) begin
            alu_flags[FLAG_C] = add_sum[WIDTH];
            alu_flags[FLAG_V] = (add_x[WIDTH-1] == add_y[WIDTH-1]) &&
                                (add_sum[WIDTH-1] != add_x[WIDTH-1]);
        end else begin
            alu_flags[FLAG_C] = flags_in[FLAG_C];
            alu_flags[FLAG_V] = flags_in[FLAG_V];
        end
    end

    // Control FSM and next values of all output registers
    always_comb begin
        state_d     = state_q;
        result_d    = result_q;
        flags_d     = flags_q;
        done_d      = 1'b0;
        wr_en_d     = 1'b0;
        flag_load_d = 1'b0;
        busy_d      = busy_q;
        s_lat_d     = s_lat_q;
        c_lat_d     = c_lat_q;
        v_lat_d     = v_lat_q;
        mul_go      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (mul) begin
                        mul_go  = 1'b1;
                        s_lat_d = s_bit;
                        c_lat_d = flags_in[FLAG_C];
                        v_lat_d = flags_in[FLAG_V];
                        busy_d  = 1'b1;
                        state_d = ST_MUL;
                    end else begin
                        result_d    = alu_res;
                        flags_d     = alu_flags;
                        done_d      = 1'b1;
                        wr_en_d     = !is_test_op(op);
                        flag_load_d = is_test_op(op) || s_bit;
                    end
                end
            end
            ST_MUL: begin
                // start is deliberately ignored here: no queuing while busy
                if (mul_last) begin
                    result_d          = mul_product;
                    flags_d[FLAG_Z]   = (mul_product == '0);
                    flags_d[FLAG_N]   = mul_product[WIDTH-1];
                    flags_d[FLAG_C]   = c_lat_q;
                    flags_d[FLAG_V]   = v_lat_q;
                    done_d            = 1'b1;
                    wr_en_d           = 1'b1;
                    flag_load_d       = s_lat_q;
                    busy_d            = 1'b0;
                    state_d           = ST_IDLE;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset wins over a simultaneous start
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            result_q    <= '0;
            flags_q     <= '0;
            done_q      <= 1'b0;
            wr_en_q     <= 1'b0;
            flag_load_q <= 1'b0;
            busy_q      <= 1'b0;
            s_lat_q     <= 1'b0;
            c_lat_q     <= 1'b0;
            v_lat_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            result_q    <= result_d;
            flags_q     <= flags_d;
            done_q      <= done_d;
            wr_en_q     <= wr_en_d;
            flag_load_q <= flag_load_d;
            busy_q      <= busy_d;
            s_lat_q     <= s_lat_d;
            c_lat_q     <= c_lat_d;
            v_lat_q     <= v_lat_d;
        end
    end

    assign result    = result_q;
    assign z_out     = flags_q[FLAG_Z];
    assign n_out     = flags_q[FLAG_N];
    assign c_out     = flags_q[FLAG_C];
    assign v_out     = flags_q[FLAG_V];
    assign done      = done_q;
    assign wr_en     = wr_en_q;
    assign flag_load = flag_load_q;
    assign busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_flag_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_flag_unit
// Description : Directed self-checking bench for alu_flag_unit (WIDTH=32).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_flag_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  op;
    logic        mul;
    logic        s_bit;
    logic [31:0] a, b;
    logic [3:0]  flags_in;
    logic [31:0] result;
    logic        z_out, n_out, c_out, v_out;
    logic        flag_load, wr_en, done, busy;
    logic [3:0]  fl;

    int checks = 0;
    int errors = 0;

    assign fl = {v_out, c_out, n_out, z_out};

    alu_flag_unit #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .mul       (mul),
        .s_bit     (s_bit),
        .a         (a),
        .b         (b),
        .flags_in  (flags_in),
        .result    (result),
        .z_out     (z_out),
        .n_out     (n_out),
        .c_out     (c_out),
        .v_out     (v_out),
        .flag_load (flag_load),
        .wr_en     (wr_en),
        .done      (done),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Present one request for exactly one sampling edge
    task automatic issue(input logic [3:0] i_op, input logic [31:0] i_a,
                         input logic [31:0] i_b, input logic i_s,
                         input logic [3:0] i_fl, input logic i_mul);
        op = i_op; a = i_a; b = i_b; s_bit = i_s; flags_in = i_fl; mul = i_mul;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        op = 4'h4; a = 32'd1; b = 32'd1; s_bit = 1'b1; flags_in = 4'hF; mul = 1'b0;
        start = 1'b1;
        tick();
        tick();
        start = 1'b0;
        checks++;
        if ({result, fl, done, flag_load, wr_en, busy} !== 40'd0) begin
            errors++;
            $display("FAIL reset_state: got result=%h flags=%b d/fl/wr/busy=%b%b%b%b, expected all zero",
                     result, fl, done, flag_load, wr_en, busy);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_add_overflow;
        issue(4'h4, 32'h7FFF_FFFF, 32'h1, 1'b1, 4'b0000, 1'b0);
        checks++;
        if (result !== 32'h8000_0000 || fl !== 4'b1010 || flag_load !== 1'b1 ||
            wr_en !== 1'b1 || done !== 1'b1) begin
            errors++;
            $display("FAIL add_overflow: got result=%h flags=%b fl=%b wr=%b done=%b, expected 80000000 1010 1 1 1",
                     result, fl, flag_load, wr_en, done);
        end
        tick();
        checks++;
        if (done !== 1'b0 || wr_en !== 1'b0 || flag_load !== 1'b0 || result !== 32'h8000_0000) begin
            errors++;
            $display("FAIL add_pulse_width: got done=%b wr=%b fl=%b result=%h, expected 0 0 0 80000000",
                     done, wr_en, flag_load, result);
        end
    endtask

    task automatic test_cmp;
        issue(4'hA, 32'd5, 32'd5, 1'b0, 4'b0000, 1'b0);
        checks++;
        if (wr_en !== 1'b0 || flag_load !== 1'b1 || fl !== 4'b0101 || done !== 1'b1) begin
            errors++;
            $display("FAIL cmp_equal: got wr=%b fl=%b flags=%b done=%b, expected 0 1 0101 1",
                     wr_en, flag_load, fl, done);
        end
    endtask

    task automatic test_adc;
        issue(4'h5, 32'hFFFF_FFFF, 32'h0, 1'b1, 4'b0100, 1'b0);
        checks++;
        if (result !== 32'h0 || fl !== 4'b0101) begin
            errors++;
            $display("FAIL adc_carry_in: got result=%h flags=%b, expected 00000000 0101", result, fl);
        end
    endtask

    task automatic test_and;
        issue(4'h0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1'b0, 4'b1111, 1'b0);
        checks++;
        if (result !== 32'h00F0_00F0 || flag_load !== 1'b0 || wr_en !== 1'b1 || fl !== 4'b1100) begin
            errors++;
            $display("FAIL and_logical: got result=%h fl=%b wr=%b flags=%b, expected 00f000f0 0 1 1100",
                     result, flag_load, wr_en, fl);
        end
    endtask

    task automatic test_mul;
        int          done_cnt = 0;
        int          done_at  = -1;
        logic [31:0] cap_res  = '0;
        logic [3:0]  cap_fl   = '0;
        logic        cap_wr   = 1'b0;
        logic        cap_ld   = 1'b0;
        logic        cap_busy = 1'b1;
        issue(4'h4, 32'h0000_FFFF, 32'h0001_0001, 1'b1, 4'b1100, 1'b1);
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL mul_busy_start: got busy=%b done=%b, expected 1 0", busy, done);
        end
        for (int i = 1; i <= 40; i++) begin
            start = (i == 5 || i == 10 || i == 20);
            tick();
            start = 1'b0;
            if (done === 1'b1) begin
                done_cnt++;
                done_at  = i;
                cap_res  = result;
                cap_fl   = fl;
                cap_wr   = wr_en;
                cap_ld   = flag_load;
                cap_busy = busy;
            end
        end
        checks++;
        if (done_cnt != 1 || done_at != 32) begin
            errors++;
            $display("FAIL mul_latency: got %0d done pulses, last at cycle %0d, expected 1 at cycle 32",
                     done_cnt, done_at);
        end
        checks++;
        if (cap_res !== 32'hFFFF_FFFF || cap_fl !== 4'b1110 || cap_wr !== 1'b1 ||
            cap_ld !== 1'b1 || cap_busy !== 1'b0) begin
            errors++;
            $display("FAIL mul_result: got result=%h flags=%b wr=%b fl=%b busy=%b, expected ffffffff 1110 1 1 0",
                     cap_res, cap_fl, cap_wr, cap_ld, cap_busy);
        end
    endtask

    task automatic test_mul_reset;
        int done_cnt = 0;
        issue(4'h0, 32'd3, 32'd7, 1'b1, 4'b1111, 1'b1);
        for (int i = 1; i < 10; i++) begin
            tick();
        end
        reset = 1'b1;
        tick();
        checks++;
        if ({result, fl, done, flag_load, wr_en, busy} !== 40'd0) begin
            errors++;
            $display("FAIL mul_reset_state: got result=%h flags=%b d/fl/wr/busy=%b%b%b%b, expected all zero",
                     result, fl, done, flag_load, wr_en, busy);
        end
        reset = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done === 1'b1) done_cnt++;
        end
        checks++;
        if (done_cnt != 0) begin
            errors++;
            $display("FAIL mul_reset_no_done: got %0d done pulses, expected 0", done_cnt);
        end
        issue(4'h4, 32'd2, 32'd3, 1'b0, 4'b0000, 1'b0);
        checks++;
        if (result !== 32'd5 || done !== 1'b1 || wr_en !== 1'b1 || flag_load !== 1'b0) begin
            errors++;
            $display("FAIL add_after_reset: got result=%h done=%b wr=%b fl=%b, expected 00000005 1 1 0",
                     result, done, wr_en, flag_load);
        end
    endtask

    task automatic test_back_to_back;
        issue(4'h4, 32'd1, 32'd2, 1'b1, 4'b0000, 1'b0);
        checks++;
        if (result !== 32'd3 || done !== 1'b1 || fl !== 4'b0000) begin
            errors++;
            $display("FAIL b2b_add: got result=%h done=%b flags=%b, expected 00000003 1 0000", result, done, fl);
        end
        issue(4'h2, 32'd3, 32'd5, 1'b0, 4'b0000, 1'b0);
        checks++;
        if (result !== 32'hFFFF_FFFE || done !== 1'b1 || fl !== 4'b0010 ||
            wr_en !== 1'b1 || flag_load !== 1'b0) begin
            errors++;
            $display("FAIL b2b_sub_borrow: got result=%h done=%b flags=%b wr=%b fl=%b, expected fffffffe 1 0010 1 0",
                     result, done, fl, wr_en, flag_load);
        end
        issue(4'h7, 32'd1, 32'd5, 1'b1, 4'b0000, 1'b0);
        checks++;
        if (result !== 32'd3 || done !== 1'b1 || fl !== 4'b0100) begin
            errors++;
            $display("FAIL b2b_rsc: got result=%h done=%b flags=%b, expected 00000003 1 0100", result, done, fl);
        end
        issue(4'h9, 32'h5A5A_0000, 32'h5A5A_0000, 1'b0, 4'b0000, 1'b0);
        checks++;
        if (result !== 32'h0 || fl !== 4'b0001 || wr_en !== 1'b0 || flag_load !== 1'b1 || done !== 1'b1) begin
            errors++;
            $display("FAIL b2b_teq: got result=%h flags=%b wr=%b fl=%b done=%b, expected 00000000 0001 0 1 1",
                     result, fl, wr_en, flag_load, done);
        end
        tick();
        checks++;
        if (done !== 1'b0 || result !== 32'h0) begin
            errors++;
            $display("FAIL b2b_idle_hold: got done=%b result=%h, expected 0 00000000", done, result);
        end
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; op = 4'h0; mul = 1'b0; s_bit = 1'b0;
        a = '0; b = '0; flags_in = '0;
        test_reset();
        test_add_overflow();
        test_cmp();
        test_adc();
        test_and();
        test_mul();
        test_mul_reset();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
